// File: rtl/pixel_framebuffer_writer.sv
// Buffers pixels from a line drawing engine, clips them against the screen and
// issues one framebuffer write per on-screen pixel with a held request/ack handshake.
module pixel_framebuffer_writer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [31:0] in_pixel,
    input  logic        in_rts,
    output logic        in_rtr,
    output logic [18:0] mem_addr,
    output logic [11:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic        clr_stats,
    output logic [15:0] pix_written,
    output logic [15:0] pix_clipped,
    output logic        idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [10:0]      H_LIMIT       = 11'(H_RES);
    localparam logic [10:0]      V_LIMIT       = 11'(V_RES);
    localparam logic [18:0]      H_RES_W       = 19'(H_RES);
    localparam logic [15:0]      CNT_MAX       = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_WRITE
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [31:0] work_pix_q, work_pix_d;
    logic [18:0] mem_addr_q, mem_addr_d;
    logic [11:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] pix_written_q, pix_written_d;
    logic [15:0] pix_clipped_q, pix_clipped_d;

    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        inc_written;
    logic        inc_clipped;
    logic [9:0]  work_x;
    logic [9:0]  work_y;
    logic [11:0] work_color;
    logic        in_range;
    logic [18:0] addr_calc;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == FIFO_FULL_CNT);

    // Ready is held low while reset is asserted so nothing is captured in that cycle.
    assign in_rtr = ~fifo_full & ~rst_;
    assign push   = in_rts & in_rtr;

    assign work_x     = work_pix_q[31:22];
    assign work_y     = work_pix_q[21:12];
    assign work_color = work_pix_q[11:0];
    assign in_range   = ({1'b0, work_x} < H_LIMIT) && ({1'b0, work_y} < V_LIMIT);
    assign addr_calc  = 19'(work_y) * H_RES_W + 19'(work_x);

    // ------------------------------------------------------------------
    // FIFO pointer and occupancy bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        work_pix_d  = work_pix_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        inc_written = 1'b0;
        inc_clipped = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    work_pix_d = fifo_mem_q[rd_ptr_q];
                    state_d    = ST_CALC;
                end
            end

            ST_CALC: begin
                if (!in_range) begin
                    inc_clipped = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    mem_addr_d  = addr_calc;
                    mem_wdata_d = work_color;
                    mem_we_d    = 1'b1;
                    state_d     = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // Address and data stay put until the memory takes the write.
                if (mem_ack) begin
                    mem_we_d    = 1'b0;
                    inc_written = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating statistics; a clear in the same cycle beats an increment
    // ------------------------------------------------------------------
    always_comb begin
        pix_written_d = pix_written_q;
        pix_clipped_d = pix_clipped_q;
        if (clr_stats) begin
            pix_written_d = '0;
            pix_clipped_d = '0;
        end else begin
            if (inc_written && (pix_written_q != CNT_MAX)) begin
                pix_written_d = pix_written_q + 16'd1;
            end
            if (inc_clipped && (pix_clipped_q != CNT_MAX)) begin
                pix_clipped_d = pix_clipped_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            work_pix_q    <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_we_q      <= 1'b0;
            pix_written_q <= '0;
            pix_clipped_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            work_pix_q    <= work_pix_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            pix_written_q <= pix_written_d;
            pix_clipped_q <= pix_clipped_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; emptiness is tracked
    // by the occupancy count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= in_pixel;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign pix_written = pix_written_q;
    assign pix_clipped = pix_clipped_q;
    assign idle        = fifo_empty && (state_q == ST_IDLE);

endmodule
